// File: rtl/gpr_scoreboard_if.sv
//------------------------------------------------------------------------------
// Module      : gpr_scoreboard_if
// Description : Issue and writeback-retire bundle between decode/issue and the
//               GPR scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gpr_scoreboard_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] issue_rj;
    logic [4:0] issue_rk;
    logic       issue_rj_en;
    logic       issue_rk_en;
    logic [4:0] issue_rd;
    logic       issue_rd_en;
    logic       wb0_valid;
    logic [4:0] wb0_rd;
    logic       wb1_valid;
    logic [4:0] wb1_rd;

    modport master (
        output issue_valid, issue_rj, issue_rk, issue_rj_en, issue_rk_en,
        output issue_rd, issue_rd_en, wb0_valid, wb0_rd, wb1_valid, wb1_rd,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_rj, issue_rk, issue_rj_en, issue_rk_en,
        input  issue_rd, issue_rd_en, wb0_valid, wb0_rd, wb1_valid, wb1_rd,
        output issue_ready
    );
endinterface

`default_nettype wire

// File: rtl/gpr_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : gpr_scoreboard
// Description : Per-GPR pending-write counters with RAW/saturation issue stall.
//               Define SB_WB_BYPASS_EN to let a same-cycle writeback release a
//               dependent issue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpr_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    input  wire logic               flush,
    gpr_scoreboard_if.slave         sb,
    output logic [31:0]             busy,
    output logic [STALL_W-1:0]      stall_cnt,
    output logic                    sb_err
);

    localparam logic [CNT_W-1:0]   c_cnt_max   = '1;
    localparam logic [STALL_W-1:0] c_stall_max = '1;

    logic [31:0][CNT_W-1:0] r_cnt;
    logic [STALL_W-1:0]     r_stall_cnt;
    logic                   r_sb_err;

    logic [31:0]            w_wb0_oh;
    logic [31:0]            w_wb1_oh;
    logic [31:0]            w_inc;
    logic [31:0]            w_under;
    logic [31:0][1:0]       w_dec;
    logic [31:0][CNT_W-1:0] w_eff;
    logic [31:0][CNT_W-1:0] w_cnt_next;
    logic                   w_src_haz;
    logic                   w_sat_haz;
    logic                   w_ready;
    logic                   w_fire;

    // Retire decode and the counter value seen by the hazard check.
    always_comb begin
        logic [CNT_W:0] v_cnt;
        logic [CNT_W:0] v_dec;
        w_wb0_oh    = sb.wb0_valid ? (32'd1 << sb.wb0_rd) : 32'd0;
        w_wb1_oh    = sb.wb1_valid ? (32'd1 << sb.wb1_rd) : 32'd0;
        w_wb0_oh[0] = 1'b0;
        w_wb1_oh[0] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w_dec[i] = {1'b0, w_wb0_oh[i]} + {1'b0, w_wb1_oh[i]};
            v_cnt    = {1'b0, r_cnt[i]};
            v_dec    = (CNT_W+1)'(w_dec[i]);
`ifdef SB_WB_BYPASS_EN
            w_eff[i] = (v_cnt > v_dec) ? CNT_W'(v_cnt - v_dec) : '0;
`else
            w_eff[i] = r_cnt[i];
`endif
        end
        w_eff[0] = '0;
    end

    always_comb begin
        w_src_haz = (sb.issue_rj_en && (sb.issue_rj != 5'd0) && (w_eff[sb.issue_rj] != '0))
                 || (sb.issue_rk_en && (sb.issue_rk != 5'd0) && (w_eff[sb.issue_rk] != '0));
        w_sat_haz = sb.issue_rd_en && (sb.issue_rd != 5'd0) && (w_eff[sb.issue_rd] == c_cnt_max);
        w_ready   = !flush && !w_src_haz && !w_sat_haz;
        w_fire    = sb.issue_valid && w_ready;
        w_inc     = (w_fire && sb.issue_rd_en) ? (32'd1 << sb.issue_rd) : 32'd0;
        w_inc[0]  = 1'b0;
    end

    // Underflow floors the counter at zero and flags a stray writeback.
    always_comb begin
        logic [CNT_W:0] v_sum;
        logic [CNT_W:0] v_dec;
        for (int i = 0; i < 32; i++) begin
            v_sum   = {1'b0, r_cnt[i]} + {{CNT_W{1'b0}}, w_inc[i]};
            v_dec   = (CNT_W+1)'(w_dec[i]);
            if (v_sum < v_dec) begin
                w_under[i]    = 1'b1;
                w_cnt_next[i] = '0;
            end else begin
                w_under[i]    = 1'b0;
                w_cnt_next[i] = CNT_W'(v_sum - v_dec);
            end
        end
        w_under[0]    = 1'b0;
        w_cnt_next[0] = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (sb.issue_valid && !w_ready && (r_stall_cnt != c_stall_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sb_err <= 1'b0;
        end else if (!flush && (w_under != 32'd0)) begin
            r_sb_err <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            busy[i] = (r_cnt[i] != '0);
        end
        busy[0] = 1'b0;
    end

    assign sb.issue_ready = w_ready;
    assign stall_cnt      = r_stall_cnt;
    assign sb_err         = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_gpr_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : tb_gpr_scoreboard
// Description : Directed plus randomized bench against a per-register model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_gpr_scoreboard;

    localparam int CNT_W     = 2;
    localparam int STALL_W   = 16;
    localparam int MAXC      = (1 << CNT_W) - 1;
    localparam int STALL_MAX = (1 << STALL_W) - 1;

    logic               clk    = 1'b0;
    logic               resetn = 1'b0;
    logic               flush  = 1'b0;
    logic [31:0]        busy;
    logic [STALL_W-1:0] stall_cnt;
    logic               sb_err;

    gpr_scoreboard_if sbif ();

    gpr_scoreboard #(
        .CNT_W   (CNT_W),
        .STALL_W (STALL_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .sb        (sbif),
        .busy      (busy),
        .stall_cnt (stall_cnt),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_cnt [32];
    int m_stall;
    bit m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_dec(input int i);
        int d = 0;
        if (i == 0) return 0;
        if (sbif.wb0_valid && int'(sbif.wb0_rd) == i) d++;
        if (sbif.wb1_valid && int'(sbif.wb1_rd) == i) d++;
        return d;
    endfunction

    function automatic int m_eff(input int i);
        int e = m_cnt[i];
`ifdef SB_WB_BYPASS_EN
        e = e - m_dec(i);
        if (e < 0) e = 0;
`endif
        return e;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (sbif.issue_rj_en && sbif.issue_rj != 0 && m_eff(int'(sbif.issue_rj)) != 0) return 1'b0;
        if (sbif.issue_rk_en && sbif.issue_rk != 0 && m_eff(int'(sbif.issue_rk)) != 0) return 1'b0;
        if (sbif.issue_rd_en && sbif.issue_rd != 0 && m_eff(int'(sbif.issue_rd)) == MAXC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_stall = 0;
        m_err   = 1'b0;
    endtask

    task automatic drive(input bit v, input int rj, input bit rje, input int rk, input bit rke,
                         input int rd, input bit rde, input bit w0v, input int w0,
                         input bit w1v, input int w1, input bit fl);
        sbif.issue_valid = v;
        sbif.issue_rj    = 5'(rj);
        sbif.issue_rj_en = rje;
        sbif.issue_rk    = 5'(rk);
        sbif.issue_rk_en = rke;
        sbif.issue_rd    = 5'(rd);
        sbif.issue_rd_en = rde;
        sbif.wb0_valid   = w0v;
        sbif.wb0_rd      = 5'(w0);
        sbif.wb1_valid   = w1v;
        sbif.wb1_rd      = 5'(w1);
        flush            = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check ready, advance the model, check registered outputs.
    task automatic step(input string tag);
        bit rdy;
        bit fire;
        int v;
        #1;
        rdy = m_ready();
        check({tag, ".ready"}, 64'(sbif.issue_ready), 64'(rdy));
        fire = sbif.issue_valid && rdy;
        if (sbif.issue_valid && !rdy && m_stall < STALL_MAX) m_stall++;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                v = m_cnt[i] - m_dec(i);
                if (fire && sbif.issue_rd_en && int'(sbif.issue_rd) == i) v++;
                if (v < 0) begin
                    v     = 0;
                    m_err = 1'b1;
                end
                m_cnt[i] = v;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".busy"},  64'(busy),      64'(m_busy()));
        check({tag, ".stall"}, 64'(stall_cnt), 64'(m_stall));
        check({tag, ".err"},   64'(sb_err),    64'(m_err));
    endtask

    initial begin
        int a;
        int rj, rk, rd;
        m_reset();
        idle();
        #3;
        check("rst.busy",  64'(busy),      64'd0);
        check("rst.stall", 64'(stall_cnt), 64'd0);
        check("rst.err",   64'(sb_err),    64'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        step("idle");

        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        step("iss5");
        check("busy5", 64'(busy), 64'h20);

        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        step("raw5a");
        step("raw5b");
        check("stall2", 64'(stall_cnt), 64'd2);
        drive(1, 5, 1, 0, 0, 6, 1, 1, 5, 0, 0, 0);
        step("wb5");
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        step("dep5");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        step("ret6");

        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("sat7");
        check("busy7", 64'(busy[7]), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        step("dual7");
        check("busy7dual", 64'(busy[7]), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        step("ret7");

        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        step("iss9");
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 9, 0);
        step("same9");
        check("busy9", 64'(busy[9]), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step("ret9");

        drive(1, 11, 1, 0, 0, 11, 1, 1, 12, 0, 0, 0);
        step("err12");
        check("err12set", 64'(sb_err), 64'd1);
        drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        step("zero");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        step("ret11");

        for (int r = 1; r <= 4; r = r * 2) begin
            drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0, 0, 0);
            step("pend");
        end
        drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0, 1);
        step("flush");
        check("flushbusy", 64'(busy), 64'd0);
        check("flusherr",  64'(sb_err), 64'd1);

        for (int n = 0; n < 600; n++) begin
            rj = $urandom_range(7);
            rk = $urandom_range(7);
            rd = $urandom_range(7);
            a  = $urandom_range(7, 1);
            drive($urandom_range(9) < 7, rj, $urandom_range(1), rk, $urandom_range(1),
                  rd, $urandom_range(3) != 0,
                  $urandom_range(1), (m_cnt[a] > 0) ? a : int'($urandom_range(7)),
                  $urandom_range(2) == 0, $urandom_range(7, 1),
                  $urandom_range(39) == 0);
            step("rnd");
        end

        drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        step("pre_rst");
        idle();
        #2;
        resetn = 1'b0;
        #1;
        check("arst.busy",  64'(busy),      64'd0);
        check("arst.stall", 64'(stall_cnt), 64'd0);
        check("arst.err",   64'(sb_err),    64'd0);
        m_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        step("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
